// File: rtl/noc_pkg.sv
// Shared NoC definitions: arbiter FSM state encoding, packet length limit and
// the requester index assignment on the return byte channel.
package noc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } noc_arb_state_t;

    localparam int NOC_MAX_PKT_BYTES = 20;

    localparam int NOC_REQ_RD_RESP = 0;
    localparam int NOC_REQ_WR_RESP = 1;
    localparam int NOC_REQ_MSG     = 2;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after
// (last_winner + 1) mod NUM_REQ.
module noc_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    assign any_req = |req;

    // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
    always_comb begin
        winner = last_winner;
        idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDX_W'((int'(last_winner) + i) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/noc_resp_arbiter.sv
// Packet round-robin arbiter for the NoC return byte channel with a registered
// output stage. Optional overlong-packet watchdog: NOC_ARB_WATCHDOG_EN.
module noc_resp_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int MAX_PKT_BYTES = NOC_MAX_PKT_BYTES,
    parameter int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [7:0]           CMD_WRITE,
    output logic                 ALE_WRITE,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 err_overlong,
    output noc_arb_state_t       dbg_state
);

    // Handshakes: a byte moves when valid & ready are both high at a rising edge;
    // valid may not depend on ready, and a presented byte is held until taken.
    noc_arb_state_t   state, state_d;
    logic [IDX_W-1:0] last_winner, pick_id;
    logic             any_req, first_byte, accept, out_free;
    logic             g_valid, g_last;
    logic [7:0]       g_data;
    logic [NUM_REQ-1:0] grant_sel;

    noc_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req         (req_valid),
        .last_winner (last_winner),
        .winner      (pick_id),
        .any_req     (any_req)
    );

    assign out_free  = ~tx_valid | tx_ready;
    assign grant_sel = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    assign dbg_state = state;

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

`ifdef NOC_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);
    logic [CNT_W-1:0] byte_cnt;
    logic             trunc, err_q;
`endif

    always_comb begin
        state_d   = state;
        req_ready = '0;
        accept    = 1'b0;
`ifdef NOC_ARB_WATCHDOG_EN
        trunc     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (any_req) state_d = ST_SEND;
            end
            ST_SEND: begin
                accept    = g_valid & out_free;
                req_ready = grant_sel & {NUM_REQ{accept}};
                if (accept && g_last) begin
                    state_d = ST_GAP;
                end
`ifdef NOC_ARB_WATCHDOG_EN
                else if (accept && byte_cnt == CNT_W'(MAX_PKT_BYTES - 1)) begin
                    state_d = ST_DRAIN;
                    trunc   = 1'b1;
                end
`endif
            end
            ST_GAP: state_d = ST_IDLE;
`ifdef NOC_ARB_WATCHDOG_EN
            // Swallow the rest of the overlong packet without touching the link.
            ST_DRAIN: begin
                req_ready = grant_sel & {NUM_REQ{g_valid}};
                if (g_valid && g_last) state_d = ST_GAP;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
            first_byte  <= 1'b0;
            tx_valid    <= 1'b0;
            CMD_WRITE   <= 8'h00;
            ALE_WRITE   <= 1'b0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && any_req) begin
                grant_id   <= pick_id;
                first_byte <= 1'b1;
            end
            if (state == ST_GAP) last_winner <= grant_id;
            if (accept) begin
                tx_valid   <= 1'b1;
                CMD_WRITE  <= g_data;
                ALE_WRITE  <= first_byte;
                first_byte <= 1'b0;
            end else if (tx_valid && tx_ready) begin
                tx_valid  <= 1'b0;
                ALE_WRITE <= 1'b0;
            end
        end
    end

`ifdef NOC_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= trunc;
            if (state == ST_GAP) byte_cnt <= '0;
            else if (accept)     byte_cnt <= byte_cnt + 1'b1;
        end
    end
    assign err_overlong = err_q;
`else
    // Watchdog compiled out: never truncates, so this is constant 0.
    assign err_overlong = (MAX_PKT_BYTES < 0);
`endif

endmodule

// File: tb/tb_noc_resp_arbiter.sv
// Bench for noc_resp_arbiter; expectations follow NOC_ARB_WATCHDOG_EN when it
// is defined for the build.
module tb_noc_resp_arbiter;
  import noc_pkg::*;

  localparam int NUM  = 3;
  localparam int MAXB = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NUM-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [8*NUM-1:0] req_data = '0;
  logic tx_ready = 1'b0, tx_valid, ALE_WRITE, err_overlong;
  logic [7:0] CMD_WRITE;
  logic [1:0] grant_id;
  noc_arb_state_t dbg_state;

  noc_resp_arbiter #(.NUM_REQ(NUM), .MAX_PKT_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .CMD_WRITE(CMD_WRITE), .ALE_WRITE(ALE_WRITE), .grant_id(grant_id),
    .err_overlong(err_overlong), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [9:0] src_q[NUM][$];   // {hdr, last, byte} still to be offered
  logic [9:0] m_q[NUM][$];
  logic [9:0] exp_q[$];        // {final, ale, byte} expected on the link
  int exp_gnt[$];
  int m_last = NUM - 1;
  int exp_err = 0, err_seen = 0, n_link = 0, exp_link = 0;
  bit gap_chk = 0, rand_ready = 0, bubble_en = 0, chk_bp = 0;
  int stall_at = -1, stall_left = 0;
  bit prev_stall = 0, prev_final = 0;
  logic [9:0] prev_out = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] b, input bit last);
    bit hdr;
    hdr = (src_q[r].size() == 0) || src_q[r][$][8];
    src_q[r].push_back({hdr, last, b});
  endtask

  task automatic add_pkt_rand(input int r, input int len);
    for (int k = 0; k < len; k++) add_byte(r, 8'($urandom), k == len - 1);
  endtask

  // Reference: packet-level round robin over the queued packets, with optional truncation.
  task automatic model_build();
    int pick, k, len, lim;
    bit any;
    logic [9:0] pkt[$];
    logic [9:0] e;
`ifdef NOC_ARB_WATCHDOG_EN
    lim = MAXB;
`else
    lim = 1000;
`endif
    for (int i = 0; i < NUM; i++) m_q[i] = src_q[i];
    forever begin
      any = 0;
      for (int i = 0; i < NUM; i++) if (m_q[i].size() > 0) any = 1;
      if (!any) break;
      pick = -1;
      for (int s = 1; s <= NUM; s++) begin
        k = (m_last + s) % NUM;
        if (pick < 0 && m_q[k].size() > 0) pick = k;
      end
      exp_gnt.push_back(pick);
      pkt.delete();
      do begin
        e = m_q[pick].pop_front();
        pkt.push_back(e);
      end while (e[8] == 1'b0);
      len = pkt.size();
      if (len > lim) exp_err++;
      for (int j = 0; j < len && j < lim; j++)
        exp_q.push_back({(j == len - 1) || (j == lim - 1), j == 0, pkt[j][7:0]});
      m_last = pick;
    end
  endtask

  task automatic prepare();
    exp_q.delete();
    exp_gnt.delete();
    exp_err = 0; err_seen = 0; n_link = 0;
    model_build();
    exp_link = exp_q.size();
  endtask

  function automatic int pending();
    int p;
    p = exp_q.size();
    for (int i = 0; i < NUM; i++) p += src_q[i].size();
    return p;
  endfunction

  // driver + monitor for one clock: drive at negedge, observe handshakes 1ns later
  task automatic step_cycle();
    logic [9:0] e;
    @(negedge clk);
    for (int i = 0; i < NUM; i++) begin
      if (src_q[i].size() > 0) begin
        e = src_q[i][0];
        req_valid[i] = e[9] | ~(bubble_en && $urandom_range(0, 3) == 0);
        req_last[i] = e[8];
        req_data[8*i +: 8] = e[7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'($urandom_range(0, 1));
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
    if (stall_left > 0) begin
      tx_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    else tx_ready = 1'b1;
    #1;
    if (prev_stall) check("hold", {tx_valid, ALE_WRITE, CMD_WRITE}, prev_out);
    if (gap_chk && prev_final) check("gap", tx_valid, 0);
    if (chk_bp && tx_valid && !tx_ready) check("bp_ready", req_ready, 0);
    check("ready_onehot", $countones(req_ready) <= 1, 1);
    if (err_overlong) err_seen++;
    prev_final = 0;
    if (tx_valid && tx_ready) begin
      n_link++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("link", {ALE_WRITE, CMD_WRITE}, e[8:0]);
        prev_final = e[9];
      end
      if (stall_at > 0 && n_link == stall_at) begin
        stall_left = 3;
        stall_at = -1;
      end
    end
    prev_stall = tx_valid & ~tx_ready;
    prev_out = {tx_valid, ALE_WRITE, CMD_WRITE};
    for (int i = 0; i < NUM; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e = src_q[i].pop_front();
        if (e[9]) begin
          check("grant_order", i, exp_gnt.size() > 0 ? exp_gnt.pop_front() : -1);
          check("grant_id", grant_id, i);
        end
      end
    end
  endtask

  task automatic run_step(input int budget);
    int n;
    n = 0;
    prepare();
    while (n < budget && pending() > 0) begin
      step_cycle();
      n++;
    end
    repeat (4) step_cycle();
    check("step_done", pending(), 0);
    check("link_count", n_link, exp_link);
    check("err_pulses", err_seen, exp_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txv"}, tx_valid, 0);
    check({tag, "_cmd"}, CMD_WRITE, 8'h00);
    check({tag, "_ale"}, ALE_WRITE, 0);
    check({tag, "_rdy"}, req_ready, 0);
    check({tag, "_gnt"}, grant_id, 0);
    check({tag, "_err"}, err_overlong, 0);
  endtask

  initial begin
    // reset defaults
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NUM - 1;

    // latency: request from 1 at t, grant/ready at t+1, header at t+2
    @(negedge clk);
    req_valid = 3'b010; req_data = {8'h00, 8'h5A, 8'h00}; req_last = 3'b010; tx_ready = 1'b1;
    @(posedge clk); #1;
    check("lat_grant", grant_id, 1);
    check("lat_ready", req_ready, 3'b010);
    check("lat_txv_early", tx_valid, 0);
    @(posedge clk); #1;
    req_valid = '0;
    check("lat_txv", tx_valid, 1);
    check("lat_data", CMD_WRITE, 8'h5A);
    check("lat_ale", ALE_WRITE, 1);
    repeat (4) @(negedge clk);
    m_last = 1;

    // single 4-byte packet, link always ready
    gap_chk = 1;
    add_byte(1, 8'hA0, 0); add_byte(1, 8'h11, 0); add_byte(1, 8'h22, 0); add_byte(1, 8'h33, 1);
    run_step(100);

    // one-byte packet
    add_byte(2, 8'hC5, 1);
    run_step(100);

    // reset in the middle of a packet
    add_pkt_rand(0, 8);
    prepare();
    repeat (4) step_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    for (int i = 0; i < NUM; i++) src_q[i].delete();
    exp_q.delete(); exp_gnt.delete();
    req_valid = '0;
    prev_stall = 0; prev_final = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = NUM - 1;

    // round robin: all three with two 2-byte packets each
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NUM; i++) add_pkt_rand(i, 2);
    run_step(200);

    // backpressure: 3 stalled cycles after the second link byte
    gap_chk = 0; chk_bp = 1; stall_at = 2;
    add_pkt_rand(0, 6);
    run_step(100);
    chk_bp = 0;

    // 25-byte packet followed by another requester
    gap_chk = 1;
    add_pkt_rand(1, 25);
    add_pkt_rand(2, 3);
    run_step(300);

    // randomized traffic with link backpressure and mid-packet valid bubbles
    gap_chk = 0; rand_ready = 1; bubble_en = 1;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 6; p++) add_pkt_rand($urandom_range(0, NUM - 1), $urandom_range(1, 25));
      run_step(3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_resp_arbiter.md
# noc_resp_arbiter

Round-robin arbiter that shares the single NoC return byte channel (`CMD_WRITE[7:0]` / `ALE_WRITE`) between packet sources: read-response, write-response and message generators. It grants one requester at a time and holds the grant for a whole packet, from header byte to last byte. It drives the channel from a registered output stage with a valid/ready handshake toward the link. An optional watchdog truncates packets that exceed the longest legal NoC packet.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters. Index 0 = read-response, 1 = write-response, 2 = message.
- `MAX_PKT_BYTES`, default 20: longest legal packet including the header byte. Only used when the watchdog is compiled in.

Ports:
- `clk`, input, 1: single clock. All flops on rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `req_valid`, input, NUM_REQ: requester i presents a byte.
- `req_data`, input, 8*NUM_REQ: byte of requester i at `[8i+:8]`.
- `req_last`, input, NUM_REQ: the byte presented is the last of the packet.
- `req_ready`, output, NUM_REQ: byte of requester i is accepted this cycle.
- `tx_ready`, input, 1: link accepts the output byte.
- `tx_valid`, output, 1: `CMD_WRITE` / `ALE_WRITE` are valid.
- `CMD_WRITE`, output, 8: output byte.
- `ALE_WRITE`, output, 1: 1 on the header (first) byte of each packet.
- `grant_id`, output, clog2(NUM_REQ): index of the current or most recent winner.
- `err_overlong`, output, 1: one-cycle pulse when the watchdog truncates a packet.

## Operation
- FSM states: IDLE, SEND, GAP, DRAIN.
- **IDLE**
  - All `req_ready` = 0.
  - If any `req_valid` is set, the round-robin pick takes the first set bit at or after `(last_winner+1) mod NUM_REQ`. The winner is latched in `grant_id`; go to SEND.
- **SEND**
  - `req_ready[g] = req_valid[g] & (~tx_valid | tx_ready)`. The output register is free or draining.
  - Each accepted byte loads the output register. `ALE_WRITE` = 1 only for the first byte accepted in this grant.
  - An accepted byte with `req_last` set means go to GAP.
- **GAP**
  - One cycle; no grant.
  - The winner becomes `last_winner`. Go to IDLE.
  - Guarantees at least one non-valid cycle between packets on the link.
- **Output register**
  - `tx_valid` is set on accept.
  - `tx_valid` is cleared when `tx_ready & tx_valid` and no new accept occurs in the same cycle.
  - Data is held stable while `tx_valid & ~tx_ready`.
- Non-granted requesters always see `req_ready` = 0. They must hold their byte until accepted.
- A requester that drops `req_valid` mid-packet keeps the grant. The arbiter waits indefinitely; there is no timeout without the watchdog.

## Timing
- Reset values: `tx_valid` = 0, `CMD_WRITE` = 8'h00, `ALE_WRITE` = 0, `req_ready` = 0, `grant_id` = 0, `err_overlong` = 0, state = IDLE, `last_winner` = NUM_REQ-1 (so requester 0 wins first).
- Latency: with `req_valid` asserted in IDLE at cycle t:
  - grant registered at t+1;
  - first `req_ready` at t+1;
  - header on `CMD_WRITE` at t+2.
- Throughput: one byte per cycle while `tx_ready` = 1. Packet-to-packet overhead is 2 cycles (GAP + IDLE).
- Simultaneous requests are resolved only in IDLE. Requests arriving during SEND, GAP or DRAIN wait.
- `req_last` on the first (header) byte gives a valid 1-byte packet: `ALE_WRITE` = 1, followed by GAP.
- Reset mid-packet: all outputs return to their reset values immediately. The partial packet is lost, and no partial packet is resumed after reset.

## Configuration
- Macro: `NOC_ARB_WATCHDOG_EN`.
- **Defined**
  - A byte counter of width clog2(MAX_PKT_BYTES+1) increments on each accept in SEND.
  - If the byte accepted when the count reaches MAX_PKT_BYTES is not `req_last`:
    - pulse `err_overlong`;
    - go to DRAIN.
  - DRAIN:
    - `req_ready[g]` = `req_valid[g]`;
    - bytes are discarded and `tx_valid` is not set;
    - the accepted `req_last` goes to GAP.
  - The counter clears in GAP.
- **Undefined**
  - No counter. `err_overlong` is tied to 0. DRAIN is unreachable.
  - Packets of any length pass through.

## Structure
- Shared package `noc_pkg`:
  - FSM state enum `noc_arb_state_t`;
  - `NOC_MAX_PKT_BYTES` = 20;
  - requester index constants `NOC_REQ_RD_RESP`, `NOC_REQ_WR_RESP`, `NOC_REQ_MSG`.
- Sub-module `noc_rr_pick`: combinational round-robin picker.
  - Inputs: request vector and `last_winner`.
  - Outputs: winner index and any-request flag.
  - The FSM and the output register stay in `noc_resp_arbiter`.

## Test plan
- **Reset defaults:** assert `rst_n` = 0 mid-stream → all outputs reset within the same cycle. After release, a single request from 1 gets its header out 2 cycles after `req_valid`.
- **Single 4-byte packet:** req1 sends 0xA0, 0x11, 0x22, 0x33 (last on 0x33), `tx_ready` = 1 → link carries `ALE`=1 0xA0, then 0x11, 0x22, 0x33 on consecutive cycles, then `tx_valid` = 0 for ≥1 cycle.
- **Round-robin:** all three requesters continuously valid with 2-byte packets → grant order 0, 1, 2, 0, 1, 2; `grant_id` matches.
- **Backpressure:** `tx_ready` = 0 for 3 cycles mid-packet → `CMD_WRITE` held stable, `req_ready` = 0, no byte lost or duplicated.
- **One-byte packet:** `req_last` on the header 0xC5 → one link byte with `ALE`=1, then GAP.
- **Watchdog (with `NOC_ARB_WATCHDOG_EN`, MAX_PKT_BYTES = 20):** a 25-byte packet → 20 bytes on the link, `err_overlong` pulses once, 5 bytes drained, next requester served. Without the macro, all 25 bytes pass.
